// File: rtl/counter_array_reader.sv
// counter_array_reader: bank of NUM event counters with a valid/ready dump sequencer and optional clear-on-read
// clk, rst: clock and asynchronous active-high reset
// inc_en, inc_sel: increment strobe and target counter, accepted every cycle
// dump_req, clear_on_read: start a dump (ignored while busy) and select destructive read
// out_valid, out_ready, out_index, out_count, out_last: read-out stream, one beat per counter
// busy: dump in progress
module counter_array_reader #(
  parameter int WIDTH = 8,
  parameter int NUM = 8,
  parameter int IDXW = 3,
  parameter int SATURATE = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inc_en,
  input  logic [IDXW-1:0] inc_sel,
  input  logic            dump_req,
  input  logic            clear_on_read,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [IDXW-1:0] out_index,
  output logic [WIDTH-1:0] out_count,
  output logic            out_last,
  output logic            busy
);
  typedef enum logic {IDLE, SEND} state_t;
  state_t r_state, w_next;
  logic [IDXW-1:0] r_ptr;
  logic r_clr;
  logic w_hs;
  logic [WIDTH-1:0] w_cnt [NUM];
  always_comb begin
    w_hs = (r_state == SEND) && out_ready;
    w_next = (r_state == IDLE && dump_req) ? SEND :
             (w_hs && r_ptr == IDXW'(NUM-1)) ? IDLE : r_state;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= IDLE;
      r_ptr <= '0;
      r_clr <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && dump_req) begin
        r_ptr <= '0;
        r_clr <= clear_on_read;
      end else if (w_hs) r_ptr <= r_ptr + 1'b1;
    end
  // ptr wraps back to 0 after the last beat, so out_index idles at 0
  assign out_valid = r_state == SEND;
  assign busy = r_state == SEND;
  assign out_index = r_ptr;
  assign out_last = out_valid && r_ptr == IDXW'(NUM-1);
  assign out_count = w_cnt[r_ptr];
  for (genvar i = 0; i < NUM; i++) begin : g_cnt
    logic [WIDTH-1:0] r_c;
    logic w_inc, w_clr;
    assign w_inc = inc_en && inc_sel == IDXW'(i);
    assign w_clr = w_hs && r_clr && r_ptr == IDXW'(i);
    assign w_cnt[i] = r_c;
    // a clear coinciding with an increment leaves 1 so no event is lost
    always_ff @(posedge clk or posedge rst)
      if (rst) r_c <= '0;
      else if (w_clr) r_c <= WIDTH'(w_inc);
      else if (w_inc && !(SATURATE != 0 && &r_c)) r_c <= r_c + 1'b1;
  end
endmodule
